// File: rtl/issue_rat_freelist_mp.sv
// issue_rat_freelist_mp
// ---------------------
// Purpose: multi-port physical-register free list for the issue-stage RAT.
// Each PRF is tracked as free or allocated. Up to ACQ_PORTS PRFs are offered
// per cycle, lowest index first. Retirement hands PRFs back through the redeem
// port. A speculative allocation carries an FGR (branch checkpoint) tag:
//   - committing the FGR makes the allocation permanent;
//   - abandoning the FGR returns all of its PRFs to the pool in one cycle.
//
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   i_redeemed_prf/_valid      - PRF returned by retirement
//   o_redeemed_ready           - redeem accepted (high whenever not in reset)
//   o_acquire_prf              - offered PRF per port, port k at [k*PRF_WIDTH +: PRF_WIDTH]
//   o_acquire_ready            - port k currently has an offer
//   i_acquire_fgr              - FGR tag per port, port k at [k*FGR_WIDTH +: FGR_WIDTH]
//   i_acquire_fgr_speculative  - allocation on port k is speculative
//   i_acquire_valid            - port k takes its offer
//   i_commit_fgr/_valid        - commit an FGR
//   i_abandon_fgr/_valid       - abandon an FGR
//   o_free_count               - registered number of free PRFs
module issue_rat_freelist_mp #(
  parameter int PRF_COUNT      = 64,
  parameter int PRF_WIDTH      = 6,
  parameter int FGR_COUNT      = 16,
  parameter int FGR_WIDTH      = 4,
  parameter int ACQ_PORTS      = 2,
  parameter int INIT_ALLOCATED = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PRF_WIDTH-1:0]           i_redeemed_prf,
  input  logic                           i_redeemed_valid,
  output logic                           o_redeemed_ready,
  output logic [ACQ_PORTS*PRF_WIDTH-1:0] o_acquire_prf,
  output logic [ACQ_PORTS-1:0]           o_acquire_ready,
  input  logic [ACQ_PORTS*FGR_WIDTH-1:0] i_acquire_fgr,
  input  logic [ACQ_PORTS-1:0]           i_acquire_fgr_speculative,
  input  logic [ACQ_PORTS-1:0]           i_acquire_valid,
  input  logic [FGR_WIDTH-1:0]           i_commit_fgr,
  input  logic                           i_commit_valid,
  input  logic [FGR_WIDTH-1:0]           i_abandon_fgr,
  input  logic                           i_abandon_valid,
  output logic [PRF_WIDTH:0]             o_free_count
);

  localparam int CW = PRF_WIDTH + 1;

  logic [PRF_COUNT-1:0]                free_q, free_n;
  logic [PRF_COUNT-1:0]                spec_q, spec_n;
  logic [FGR_WIDTH-1:0]                tag_q [PRF_COUNT];
  logic [FGR_WIDTH-1:0]                tag_n [PRF_COUNT];
  logic [CW-1:0]                       count_q, count_n;
  logic [ACQ_PORTS-1:0][PRF_WIDTH-1:0] offer_idx;
  logic [ACQ_PORTS-1:0]                offer_ok;
  logic [ACQ_PORTS-1:0]                fire;
  logic                                commit_en, abandon_en;

  // Offer selection: walk the free vector from index 0 and hand the n-th free
  // PRF found to port n. Only registered state is used, so same-cycle redeem,
  // commit and abandon never influence what is offered.
  always_comb begin
    int seen;
    seen      = 0;
    offer_idx = '0;
    offer_ok  = '0;
    for (int i = 0; i < PRF_COUNT; i++) begin
      if (free_q[i]) begin
        for (int k = 0; k < ACQ_PORTS; k++) begin
          if (seen == k) begin
            offer_idx[k] = PRF_WIDTH'(i);
            offer_ok[k]  = 1'b1;
          end
        end
        if (seen < ACQ_PORTS) seen++;
      end
    end
  end

  assign o_acquire_prf    = offer_idx;
  assign o_acquire_ready  = offer_ok & {ACQ_PORTS{~reset}};
  assign o_redeemed_ready = ~reset;
  assign o_free_count     = count_q;
  assign fire             = i_acquire_valid & o_acquire_ready;

  // FGR tags outside the configured range name no checkpoint and are ignored.
  assign commit_en  = i_commit_valid  && (32'(i_commit_fgr)  < FGR_COUNT);
  assign abandon_en = i_abandon_valid && (32'(i_abandon_fgr) < FGR_COUNT);

  // Next-state update. Every term looks at pre-cycle state; the application
  // order below only resolves overlaps:
  //   - abandon after commit, so abandon wins on the same FGR;
  //   - redeem only touches allocated PRFs, so a redeem of a free PRF is a no-op;
  //   - acquire last. Acquired PRFs were free, so no other event matched them.
  // The free count is recomputed from the next free vector, which makes
  // overlapping frees count once and keeps the count within 0..PRF_COUNT.
  always_comb begin
    free_n  = free_q;
    spec_n  = spec_q;
    tag_n   = tag_q;
    count_n = '0;

    for (int i = 0; i < PRF_COUNT; i++) begin
      if (commit_en && spec_q[i] && (tag_q[i] == i_commit_fgr)) begin
        spec_n[i] = 1'b0;
      end
      if (abandon_en && spec_q[i] && !free_q[i] && (tag_q[i] == i_abandon_fgr)) begin
        free_n[i] = 1'b1;
        spec_n[i] = 1'b0;
      end
    end

    if (i_redeemed_valid && !free_q[i_redeemed_prf]) begin
      free_n[i_redeemed_prf] = 1'b1;
      spec_n[i_redeemed_prf] = 1'b0;
    end

    for (int k = 0; k < ACQ_PORTS; k++) begin
      if (fire[k]) begin
        free_n[offer_idx[k]] = 1'b0;
        spec_n[offer_idx[k]] = i_acquire_fgr_speculative[k];
        tag_n[offer_idx[k]]  = i_acquire_fgr[k*FGR_WIDTH +: FGR_WIDTH];
      end
    end

    for (int i = 0; i < PRF_COUNT; i++) begin
      count_n = count_n + CW'(free_n[i]);
    end
  end

  // State register. Reset drops every request presented in the reset cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PRF_COUNT; i++) begin
        free_q[i] <= (i >= INIT_ALLOCATED);
        spec_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
      count_q <= CW'(PRF_COUNT - INIT_ALLOCATED);
    end else begin
      free_q  <= free_n;
      spec_q  <= spec_n;
      tag_q   <= tag_n;
      count_q <= count_n;
    end
  end

endmodule

// File: tb/tb_issue_rat_freelist_mp.sv
// tb_issue_rat_freelist_mp
// ------------------------
// Directed bench for issue_rat_freelist_mp with the default parameters
// (64 PRFs, 32 allocated at reset, 2 acquire ports). Each task drives one
// scenario and checks its outputs against hand-computed values. The PRF state
// carries over from one task to the next, so the expected values in each task
// follow from the tasks before it.
module tb_issue_rat_freelist_mp;

  logic        clk;
  logic        reset;
  logic [5:0]  redeemed_prf;
  logic        redeemed_valid;
  logic        redeemed_ready;
  logic [11:0] acquire_prf;
  logic [1:0]  acquire_ready;
  logic [7:0]  acquire_fgr;
  logic [1:0]  acquire_spec;
  logic [1:0]  acquire_valid;
  logic [3:0]  commit_fgr;
  logic        commit_valid;
  logic [3:0]  abandon_fgr;
  logic        abandon_valid;
  logic [6:0]  free_count;

  int tests_run;
  int tests_failed;

  issue_rat_freelist_mp dut (
    .clk                       (clk),
    .reset                     (reset),
    .i_redeemed_prf            (redeemed_prf),
    .i_redeemed_valid          (redeemed_valid),
    .o_redeemed_ready          (redeemed_ready),
    .o_acquire_prf             (acquire_prf),
    .o_acquire_ready           (acquire_ready),
    .i_acquire_fgr             (acquire_fgr),
    .i_acquire_fgr_speculative (acquire_spec),
    .i_acquire_valid           (acquire_valid),
    .i_commit_fgr              (commit_fgr),
    .i_commit_valid            (commit_valid),
    .i_abandon_fgr             (abandon_fgr),
    .i_abandon_valid           (abandon_valid),
    .o_free_count              (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drop every request input.
  task automatic idle();
    redeemed_prf   = '0;
    redeemed_valid = 1'b0;
    acquire_fgr    = '0;
    acquire_spec   = '0;
    acquire_valid  = '0;
    commit_fgr     = '0;
    commit_valid   = 1'b0;
    abandon_fgr    = '0;
    abandon_valid  = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    tests_run++;
    if (acquire_ready !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_low: got %b expected 00", acquire_ready);
    end
    tests_run++;
    if (redeemed_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_redeem_ready_low: got %b expected 0", redeemed_ready);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (free_count !== 7'd32) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d expected 32", free_count);
    end
    tests_run++;
    if (acquire_ready !== 2'b11 || acquire_prf[5:0] !== 6'd32 || acquire_prf[11:6] !== 6'd33) begin
      tests_failed++;
      $display("[TB] FAIL reset_offers: got ready=%b p0=%0d p1=%0d expected 11/32/33",
               acquire_ready, acquire_prf[5:0], acquire_prf[11:6]);
    end
    tests_run++;
    if (redeemed_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL redeem_ready_high: got %b expected 1", redeemed_ready);
    end
  endtask

  task automatic test_dual_acquire();
    acquire_valid = 2'b11;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd30 || acquire_prf[5:0] !== 6'd34 || acquire_prf[11:6] !== 6'd35) begin
      tests_failed++;
      $display("[TB] FAIL dual_acquire: got count=%0d p0=%0d p1=%0d expected 30/34/35",
               free_count, acquire_prf[5:0], acquire_prf[11:6]);
    end
    redeemed_prf   = 6'd32;
    redeemed_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd31 || acquire_prf[5:0] !== 6'd32 || acquire_prf[11:6] !== 6'd34) begin
      tests_failed++;
      $display("[TB] FAIL redeem_reoffer: got count=%0d p0=%0d p1=%0d expected 31/32/34",
               free_count, acquire_prf[5:0], acquire_prf[11:6]);
    end
  endtask

  // Free now: 32, 34..63. Port0 offers 32 (FGR 3), port1 offers 34 (FGR 5).
  task automatic test_spec_abandon();
    acquire_valid = 2'b11;
    acquire_spec  = 2'b11;
    acquire_fgr   = {4'd5, 4'd3};
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd29) begin
      tests_failed++;
      $display("[TB] FAIL spec_acquire_count: got %0d expected 29", free_count);
    end
    abandon_fgr   = 4'd3;
    abandon_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd30 || acquire_prf[5:0] !== 6'd32 || acquire_prf[11:6] !== 6'd35) begin
      tests_failed++;
      $display("[TB] FAIL abandon_frees: got count=%0d p0=%0d p1=%0d expected 30/32/35",
               free_count, acquire_prf[5:0], acquire_prf[11:6]);
    end
  endtask

  // Free now: 32, 35..63.
  task automatic test_commit_then_abandon();
    acquire_valid = 2'b01;
    acquire_spec  = 2'b01;
    acquire_fgr   = {4'd0, 4'd7};
    step();
    idle();
    commit_fgr   = 4'd7;
    commit_valid = 1'b1;
    step();
    idle();
    abandon_fgr   = 4'd7;
    abandon_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd29 || acquire_prf[5:0] !== 6'd35) begin
      tests_failed++;
      $display("[TB] FAIL commit_blocks_abandon: got count=%0d p0=%0d expected 29/35",
               free_count, acquire_prf[5:0]);
    end
  endtask

  // Free now: 35..63. PRF 34 is still speculative under FGR 5.
  task automatic test_same_cycle();
    acquire_valid = 2'b01;
    acquire_spec  = 2'b01;
    acquire_fgr   = {4'd0, 4'd2};
    step();
    idle();
    commit_fgr    = 4'd2;
    commit_valid  = 1'b1;
    abandon_fgr   = 4'd2;
    abandon_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd29 || acquire_prf[5:0] !== 6'd35) begin
      tests_failed++;
      $display("[TB] FAIL commit_abandon_same: got count=%0d p0=%0d expected 29/35",
               free_count, acquire_prf[5:0]);
    end
    // 35 tagged FGR 4, then 36 acquired under FGR 4 while FGR 4 is abandoned.
    acquire_valid = 2'b01;
    acquire_spec  = 2'b01;
    acquire_fgr   = {4'd0, 4'd4};
    step();
    idle();
    acquire_valid = 2'b01;
    acquire_spec  = 2'b01;
    acquire_fgr   = {4'd0, 4'd4};
    abandon_fgr   = 4'd4;
    abandon_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd28 || acquire_prf[5:0] !== 6'd35 || acquire_prf[11:6] !== 6'd37) begin
      tests_failed++;
      $display("[TB] FAIL acquire_with_abandon: got count=%0d p0=%0d p1=%0d expected 28/35/37",
               free_count, acquire_prf[5:0], acquire_prf[11:6]);
    end
    // Redeem 36 while abandoning its FGR: freed and counted once.
    redeemed_prf   = 6'd36;
    redeemed_valid = 1'b1;
    abandon_fgr    = 4'd4;
    abandon_valid  = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd29 || acquire_prf[11:6] !== 6'd36) begin
      tests_failed++;
      $display("[TB] FAIL redeem_abandon_overlap: got count=%0d p1=%0d expected 29/36",
               free_count, acquire_prf[11:6]);
    end
    redeemed_prf   = 6'd40;
    redeemed_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd29) begin
      tests_failed++;
      $display("[TB] FAIL redeem_free_noop: got %0d expected 29", free_count);
    end
  endtask

  // Free now: 35..63. Only port 1 fires and takes 36.
  task automatic test_port1_only();
    acquire_valid = 2'b10;
    step();
    idle();
    tests_run++;
    if (free_count !== 7'd28 || acquire_prf[5:0] !== 6'd35 || acquire_prf[11:6] !== 6'd37) begin
      tests_failed++;
      $display("[TB] FAIL port1_only: got count=%0d p0=%0d p1=%0d expected 28/35/37",
               free_count, acquire_prf[5:0], acquire_prf[11:6]);
    end
  endtask

  // Free now: 35, 37..63 (28). 13 dual fires leave 62 and 63.
  task automatic test_empty();
    for (int n = 0; n < 13; n++) begin
      acquire_valid = 2'b11;
      step();
    end
    acquire_valid = 2'b01;
    step();
    idle();
    tests_run++;
    if (acquire_ready !== 2'b01 || free_count !== 7'd1 || acquire_prf[5:0] !== 6'd63) begin
      tests_failed++;
      $display("[TB] FAIL one_left: got ready=%b count=%0d p0=%0d expected 01/1/63",
               acquire_ready, free_count, acquire_prf[5:0]);
    end
    acquire_valid = 2'b11;
    step();
    idle();
    tests_run++;
    if (acquire_ready !== 2'b00 || free_count !== 7'd0) begin
      tests_failed++;
      $display("[TB] FAIL empty: got ready=%b count=%0d expected 00/0", acquire_ready, free_count);
    end
    redeemed_prf   = 6'd5;
    redeemed_valid = 1'b1;
    step();
    idle();
    tests_run++;
    if (acquire_ready !== 2'b01 || free_count !== 7'd1 || acquire_prf[5:0] !== 6'd5) begin
      tests_failed++;
      $display("[TB] FAIL refill_one: got ready=%b count=%0d p0=%0d expected 01/1/5",
               acquire_ready, free_count, acquire_prf[5:0]);
    end
  endtask

  // Reset with requests pending: they are dropped and state returns to reset.
  task automatic test_reset_mid();
    reset          = 1'b1;
    acquire_valid  = 2'b11;
    redeemed_prf   = 6'd6;
    redeemed_valid = 1'b1;
    step();
    tests_run++;
    if (free_count !== 7'd32 || acquire_ready !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got count=%0d ready=%b expected 32/00", free_count, acquire_ready);
    end
    reset = 1'b0;
    idle();
    #1;
    tests_run++;
    if (acquire_ready !== 2'b11 || acquire_prf[5:0] !== 6'd32 || acquire_prf[11:6] !== 6'd33) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_offers: got ready=%b p0=%0d p1=%0d expected 11/32/33",
               acquire_ready, acquire_prf[5:0], acquire_prf[11:6]);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    idle();
    test_reset();
    test_dual_acquire();
    test_spec_abandon();
    test_commit_then_abandon();
    test_same_cycle();
    test_port1_only();
    test_empty();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
